// File: rtl/icache_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : icache_pkg                                             |
// | Description : Shared types and line geometry for the instruction     |
// |               cache refill path (state encoding, beat/line sizes).   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package icache_pkg;

    // Refill controller states, explicitly 2 bits wide.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } refill_state_t;

    localparam int LINE_BYTES     = 64;
    localparam int BEAT_BITS      = 64;
    localparam int BEATS_PER_LINE = 8;
    localparam int LINE_BITS      = 512;
    localparam int BEAT_IDX_BITS  = $clog2(BEATS_PER_LINE);
    localparam int OFFSET_BITS    = $clog2(LINE_BYTES);

endpackage : icache_pkg
`default_nettype wire

// File: rtl/icache_refill_ctrl_line_buf.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : refill_line_buf                                        |
// | Description : Beat-indexed line assembly register. Each enabled      |
// |               cycle writes one 64-bit beat into slot i_idx; the whole|
// |               line is presented flat (beat b at [64b+:64]).          |
// | Ports       : clk     - clock                                        |
// |               i_we    - beat write enable                            |
// |               i_idx   - beat slot index                              |
// |               i_beat  - 64-bit beat data                             |
// |               o_line  - assembled 512-bit line                       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module refill_line_buf
    import icache_pkg::*;
(
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [BEAT_IDX_BITS-1:0] i_idx,
    input  logic [BEAT_BITS-1:0]     i_beat,
    output logic [LINE_BITS-1:0]     o_line
);

    // No reset: a stale or partial line is never written to the arrays,
    // so clearing it would only cost flops.
    for (genvar b = 0; b < BEATS_PER_LINE; b++) begin : g_beat
        logic [BEAT_BITS-1:0] r_beat;

        always_ff @(posedge clk) begin
            if (i_we && (i_idx == BEAT_IDX_BITS'(b))) begin
                r_beat <= i_beat;
            end
        end

        assign o_line[b*BEAT_BITS +: BEAT_BITS] = r_beat;
    end

endmodule : refill_line_buf
`default_nettype wire

// File: rtl/icache_refill_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : icache_refill_ctrl                                     |
// | Description : Instruction-cache refill controller. On a lookup miss  |
// |               it pulls cache_hit_o low to start a block fill, counts |
// |               eight 64-bit reply beats into a line buffer, then      |
// |               writes line, tag and valid in one DONE cycle.          |
// | Ports       : clk_i, reset_i        - clock, sync active-high reset  |
// |               req_valid_i/addr_i    - fetch request                  |
// |               lookup_hit_i          - tag compare result             |
// |               rep_ready_i/word_i    - memory reply beat              |
// |               cache_hit_o           - to memory; low = fill request  |
// |               stall_o               - fetch stall                    |
// |               fill_we_o/set_o/tag_o/line_o - cache array write port  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module icache_refill_ctrl
    import icache_pkg::*;
#(
    parameter  int NUM_SETS = 32,
    localparam int SET_BITS = $clog2(NUM_SETS),
    localparam int TAG_BITS = 26 - SET_BITS
)(
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 req_valid_i,
    input  logic [31:0]          req_addr_i,
    input  logic                 lookup_hit_i,
    input  logic                 rep_ready_i,
    input  logic [63:0]          rep_word_i,
    output logic                 cache_hit_o,
    output logic                 stall_o,
    output logic                 fill_we_o,
    output logic [SET_BITS-1:0]  fill_set_o,
    output logic [TAG_BITS-1:0]  fill_tag_o,
    output logic [LINE_BITS-1:0] fill_line_o
);

    localparam int c_BLK_BITS = 32 - OFFSET_BITS;

    refill_state_t             r_state;
    logic [BEAT_IDX_BITS-1:0]  r_beat_cnt;
    logic                      r_fill_we;
    logic [c_BLK_BITS-1:0]     r_blk_addr;   // miss address without line offset

    logic w_miss;
    logic w_capture;
    logic w_cache_hit;
    logic w_unused_offset;

    // The byte offset within the line never matters for a block fill.
    assign w_unused_offset = ^req_addr_i[OFFSET_BITS-1:0];

    assign w_miss    = (r_state == IDLE) && req_valid_i && !lookup_hit_i;
    assign w_capture = (r_state == FILL) && rep_ready_i && !reset_i;

    // Control state: beat counter and DONE strobe are registered together
    // with the state so fill_we_o is high exactly while in DONE.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state    <= IDLE;
            r_beat_cnt <= '0;
            r_fill_we  <= 1'b0;
        end else begin
            r_fill_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_miss) begin
                        r_beat_cnt <= '0;
                        r_state    <= FILL;
                    end
                end
                FILL: begin
                    if (rep_ready_i) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                        if (r_beat_cnt == BEAT_IDX_BITS'(BEATS_PER_LINE - 1)) begin
                            r_state   <= DONE;
                            r_fill_we <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // The responder sees cache_hit_o high here and goes
                    // idle, so whatever it still shows is ignored.
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Miss address latch; deliberately not reset. Only the block address
    // is kept, so later changes on req_addr_i cannot disturb the fill.
    always_ff @(posedge clk_i) begin
        if (w_miss && !reset_i) begin
            r_blk_addr <= req_addr_i[31:OFFSET_BITS];
        end
    end

    refill_line_buf u_line_buf (
        .clk    (clk_i),
        .i_we   (w_capture),
        .i_idx  (r_beat_cnt),
        .i_beat (rep_word_i),
        .o_line (fill_line_o)
    );

    // Memory-facing hit line: low asks for (or continues) a block fill.
    always_comb begin
        w_cache_hit = 1'b1;
        case (r_state)
            IDLE:    w_cache_hit = !req_valid_i || lookup_hit_i;
            FILL:    w_cache_hit = 1'b0;
            DONE:    w_cache_hit = 1'b1;
            default: w_cache_hit = 1'b1;
        endcase
        if (reset_i) begin
            w_cache_hit = 1'b1;
        end
    end

    assign cache_hit_o = w_cache_hit;
    assign stall_o     = !reset_i && req_valid_i && !((r_state == IDLE) && lookup_hit_i);
    assign fill_we_o   = r_fill_we && !reset_i;
    assign fill_set_o  = r_blk_addr[SET_BITS-1:0];
    assign fill_tag_o  = r_blk_addr[c_BLK_BITS-1:SET_BITS];

endmodule : icache_refill_ctrl
`default_nettype wire

// File: tb/tb_icache_refill_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_icache_refill_ctrl                                  |
// | Description : Self-checking bench for icache_refill_ctrl. A memory   |
// |               responder model serves block fills from a word array;  |
// |               expected lines, sets, tags and cycle timing are        |
// |               computed from address arithmetic and the miss-penalty  |
// |               rules (10 cycles plus one per responder gap cycle).    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_icache_refill_ctrl;

    localparam int NUM_SETS = 32;
    localparam int SET_BITS = 5;
    localparam int TAG_BITS = 21;
    localparam int MEM_WORDS = 4096;   // 16 KB, aliased over the address space

    logic                clk_i = 1'b0;
    logic                reset_i = 1'b1;
    logic                req_valid_i = 1'b0;
    logic [31:0]         req_addr_i = '0;
    logic                lookup_hit_i = 1'b0;
    logic                rep_ready_i = 1'b0;
    logic [63:0]         rep_word_i = '0;
    logic                cache_hit_o;
    logic                stall_o;
    logic                fill_we_o;
    logic [SET_BITS-1:0] fill_set_o;
    logic [TAG_BITS-1:0] fill_tag_o;
    logic [511:0]        fill_line_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem [MEM_WORDS];

    // responder model state
    bit          rsp_act = 1'b0;
    int          rsp_base = 0;
    int          rsp_beat = 0;
    int          rsp_gap_left = 0;
    int          rsp_gap_at = 0;
    int          cfg_gap_len = 0;
    int          cfg_gap_at = 4;
    logic        nx_ready = 1'b0;
    logic [63:0] nx_word = '0;

    // last observed fill, for directed constant checks
    logic [SET_BITS-1:0] last_set;
    logic [TAG_BITS-1:0] last_tag;
    logic [511:0]        last_line;

    icache_refill_ctrl #(.NUM_SETS(NUM_SETS)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .req_valid_i  (req_valid_i),
        .req_addr_i   (req_addr_i),
        .lookup_hit_i (lookup_hit_i),
        .rep_ready_i  (rep_ready_i),
        .rep_word_i   (rep_word_i),
        .cache_hit_o  (cache_hit_o),
        .stall_o      (stall_o),
        .fill_we_o    (fill_we_o),
        .fill_set_o   (fill_set_o),
        .fill_tag_o   (fill_tag_o),
        .fill_line_o  (fill_line_o)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- memory responder model ----------------
    task automatic rsp_present();
        if (rsp_beat >= 8) begin
            nx_ready = 1'b1;   // stale last beat while the cache is in DONE
            nx_word  = {mem[rsp_base + 15], mem[rsp_base + 14]};
        end else if (rsp_beat == rsp_gap_at && rsp_gap_left > 0) begin
            nx_ready = 1'b0;
            rsp_gap_left--;
        end else begin
            nx_ready = 1'b1;
            nx_word  = {mem[rsp_base + 2*rsp_beat + 1], mem[rsp_base + 2*rsp_beat]};
        end
    endtask

    // Decide next-cycle reply from this cycle's hit line (sampled mid-cycle).
    always @(negedge clk_i) begin
        if (reset_i) begin
            rsp_act  = 1'b0;
            nx_ready = 1'b0;
        end else if (!rsp_act) begin
            if (!cache_hit_o) begin
                rsp_act      = 1'b1;
                rsp_base     = int'(req_addr_i[13:6]) * 16;
                rsp_beat     = 0;
                rsp_gap_left = cfg_gap_len;
                rsp_gap_at   = cfg_gap_at;
                rsp_present();
            end else begin
                nx_ready = 1'b0;
            end
        end else if (cache_hit_o) begin
            rsp_act  = 1'b0;
            nx_ready = 1'b0;
        end else begin
            if (rep_ready_i) rsp_beat++;
            rsp_present();
        end
    end

    always @(posedge clk_i) begin
        #1;
        rep_ready_i = nx_ready;
        rep_word_i  = nx_word;
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [511:0] model_line(input logic [31:0] a);
        logic [511:0] l;
        int base;
        base = int'(a[13:6]) * 16;
        for (int w = 0; w < 16; w++) l[32*w +: 32] = mem[base + w];
        return l;
    endfunction

    // Present a miss in the current cycle (cycle 0) and follow it through
    // DONE. Returns positioned at the start of cycle 10+gap_len with
    // lookup_hit_i raised (the refetch hits).
    task automatic do_miss(input logic [31:0] addr, input int gap_len,
                           input int gap_at, input bit chg_addr);
        logic [511:0]        e_line;
        logic [SET_BITS-1:0] e_set;
        logic [TAG_BITS-1:0] e_tag;
        int we_cycle;
        int we_count;
        int last_c;
        e_line   = model_line(addr);
        e_set    = SET_BITS'((addr >> 6) % NUM_SETS);
        e_tag    = TAG_BITS'(addr >> (6 + SET_BITS));
        we_cycle = -1;
        we_count = 0;
        last_c   = 9 + gap_len;
        cfg_gap_len  = gap_len;
        cfg_gap_at   = gap_at;
        req_valid_i  = 1'b1;
        req_addr_i   = addr;
        lookup_hit_i = 1'b0;
        for (int c = 0; c <= last_c; c++) begin
            if (chg_addr && c == 3) req_addr_i = 32'h0000_2000;
            @(negedge clk_i);
            n_checks++;
            if (stall_o !== 1'b1) begin
                n_errors++;
                $display("FAIL miss_stall addr=%h cycle=%0d stall=%b expected=1", addr, c, stall_o);
            end
            n_checks++;
            if (cache_hit_o !== (c == last_c)) begin
                n_errors++;
                $display("FAIL miss_cache_hit addr=%h cycle=%0d cache_hit=%b expected=%b",
                         addr, c, cache_hit_o, (c == last_c));
            end
            if (fill_we_o === 1'b1) begin
                we_count++;
                if (we_cycle < 0) we_cycle = c;
                last_set  = fill_set_o;
                last_tag  = fill_tag_o;
                last_line = fill_line_o;
                n_checks++;
                if (fill_set_o !== e_set || fill_tag_o !== e_tag) begin
                    n_errors++;
                    $display("FAIL fill_set_tag addr=%h set=%h tag=%h expected set=%h tag=%h",
                             addr, fill_set_o, fill_tag_o, e_set, e_tag);
                end
                n_checks++;
                if (fill_line_o !== e_line) begin
                    n_errors++;
                    $display("FAIL fill_line addr=%h got=%h expected=%h", addr, fill_line_o, e_line);
                end
            end
            tick();
            if (we_cycle >= 0) lookup_hit_i = 1'b1;
        end
        n_checks++;
        if (we_cycle !== last_c || we_count !== 1) begin
            n_errors++;
            $display("FAIL fill_we_timing addr=%h first_cycle=%0d pulses=%0d expected cycle=%0d pulses=1",
                     addr, we_cycle, we_count, last_c);
        end
    endtask

    // Cycle after DONE: the refetch hits with no stall, then drop the request.
    task automatic end_hit();
        lookup_hit_i = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if (stall_o !== 1'b0 || cache_hit_o !== 1'b1 || fill_we_o !== 1'b0) begin
            n_errors++;
            $display("FAIL refetch_hit stall=%b cache_hit=%b fill_we=%b expected 0/1/0",
                     stall_o, cache_hit_o, fill_we_o);
        end
        tick();
        req_valid_i  = 1'b0;
        lookup_hit_i = 1'b0;
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_i      = 1'b1;
        req_valid_i  = 1'b1;
        lookup_hit_i = 1'b0;
        req_addr_i   = 32'h0000_0104;
        repeat (2) tick();
        @(negedge clk_i);
        n_checks++;
        if (cache_hit_o !== 1'b1 || stall_o !== 1'b0 || fill_we_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_outputs cache_hit=%b stall=%b fill_we=%b expected 1/0/0",
                     cache_hit_o, stall_o, fill_we_o);
        end
        tick();
        reset_i     = 1'b0;
        req_valid_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if (cache_hit_o !== 1'b1 || stall_o !== 1'b0) begin
            n_errors++;
            $display("FAIL post_reset_idle cache_hit=%b stall=%b expected 1/0", cache_hit_o, stall_o);
        end
        tick();
    endtask

    task automatic test_hit_and_idle();
        for (int i = 0; i < 40; i++) begin
            req_valid_i  = (i < 20);
            lookup_hit_i = (i < 20) ? 1'b1 : 1'($urandom_range(0, 1));
            req_addr_i   = $urandom;
            @(negedge clk_i);
            n_checks++;
            if (cache_hit_o !== 1'b1 || stall_o !== 1'b0 || fill_we_o !== 1'b0 || rep_ready_i !== 1'b0) begin
                n_errors++;
                $display("FAIL hit_idle cycle=%0d cache_hit=%b stall=%b fill_we=%b rep_ready=%b expected 1/0/0/0",
                         i, cache_hit_o, stall_o, fill_we_o, rep_ready_i);
            end
            tick();
        end
        req_valid_i  = 1'b0;
        lookup_hit_i = 1'b0;
    endtask

    task automatic test_single_miss();
        do_miss(32'h0000_0104, 0, 4, 1'b0);
        n_checks++;
        if (last_set !== 5'd4 || last_tag !== 21'd0) begin
            n_errors++;
            $display("FAIL single_set_tag set=%0d tag=%0d expected 4/0", last_set, last_tag);
        end
        n_checks++;
        if (last_line[31:0] !== 32'h1040 || last_line[511:480] !== 32'h104F) begin
            n_errors++;
            $display("FAIL single_line_ends w0=%h w15=%h expected 1040/104f",
                     last_line[31:0], last_line[511:480]);
        end
        end_hit();
    endtask

    task automatic test_back_to_back();
        do_miss(32'h0000_0040, 0, 4, 1'b0);
        n_checks++;
        if (last_set !== 5'd1) begin
            n_errors++;
            $display("FAIL b2b_first_set set=%0d expected 1", last_set);
        end
        do_miss(32'h0000_0080, 0, 4, 1'b0);   // presented in cycle 10
        n_checks++;
        if (last_set !== 5'd2) begin
            n_errors++;
            $display("FAIL b2b_second_set set=%0d expected 2", last_set);
        end
        end_hit();
    endtask

    task automatic test_gap();
        do_miss(32'h0000_0A7C, 2, 4, 1'b0);   // gap after beat 3 -> DONE in cycle 11
        end_hit();
    endtask

    task automatic test_reset_mid_fill();
        req_valid_i  = 1'b1;
        req_addr_i   = 32'h0000_0340;
        lookup_hit_i = 1'b0;
        cfg_gap_len  = 0;
        repeat (5) tick();
        reset_i = 1'b1;                        // cycle 5
        @(negedge clk_i);
        n_checks++;
        if (cache_hit_o !== 1'b1 || stall_o !== 1'b0 || fill_we_o !== 1'b0) begin
            n_errors++;
            $display("FAIL midfill_reset cache_hit=%b stall=%b fill_we=%b expected 1/0/0",
                     cache_hit_o, stall_o, fill_we_o);
        end
        tick();
        reset_i     = 1'b0;
        req_valid_i = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_i);
            n_checks++;
            if (fill_we_o !== 1'b0 || cache_hit_o !== 1'b1) begin
                n_errors++;
                $display("FAIL after_reset_no_fill cycle=%0d fill_we=%b cache_hit=%b expected 0/1",
                         i, fill_we_o, cache_hit_o);
            end
            tick();
        end
        do_miss(32'h0000_05C0, 0, 4, 1'b0);
        end_hit();
    endtask

    task automatic test_addr_change();
        do_miss(32'h0000_0284, 0, 4, 1'b1);
        end_hit();
    endtask

    task automatic test_random();
        for (int w = 0; w < MEM_WORDS; w++) mem[w] = $urandom;
        for (int k = 0; k < 8; k++) begin
            do_miss($urandom & 32'hFFFF_FFFC, int'($urandom_range(0, 3)),
                    int'($urandom_range(1, 7)), 1'b0);
            if ($urandom_range(0, 1) == 1 || k == 7) end_hit();
        end
    endtask

    initial begin
        for (int w = 0; w < MEM_WORDS; w++) mem[w] = 32'h1000 + w;
        test_reset();
        test_hit_and_idle();
        test_single_miss();
        test_back_to_back();
        test_gap();
        test_reset_mid_fill();
        test_addr_change();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_icache_refill_ctrl
`default_nettype wire

// File: doc/icache_refill_ctrl.md
# icache_refill_ctrl

Cache-side refill controller that initiates and consumes main-memory block fills for the instruction cache. On a lookup miss it drives the memory-facing hit/miss line low and counts the 64-bit reply beats. It assembles the 16-word (64-byte) line, then writes that line, its tag and its valid bit into the cache arrays in a single cycle. It sits between the instruction-cache tag/data arrays and the main-memory responder, and produces the fetch-stage stall.

## Interface
Parameters:
- NUM_SETS, 32: cache sets; power of two, ≥2. SET_BITS = $clog2(NUM_SETS). TAG_BITS = 26 − SET_BITS.

Ports:
- clk_i  in  1  clock. Single clock domain.
- reset_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  fetch request present this cycle.
- req_addr_i  in  32  fetch byte address. Held stable by the pipeline while stall_o=1.
- lookup_hit_i  in  1  tag-compare hit for req_addr_i, from the cache arrays.
- rep_ready_i  in  1  memory reply valid; rep_word_i carries the current beat.
- rep_word_i  in  64  reply beat: [31:0] is the even word, [63:32] is the odd word.
- cache_hit_o  out  1  to the memory's hit input; low requests or continues a block fill.
- stall_o  out  1  fetch stall.
- fill_we_o  out  1  one-cycle line write strobe.
- fill_set_o  out  SET_BITS  set index of the filled line.
- fill_tag_o  out  TAG_BITS  tag of the filled line.
- fill_line_o  out  512  assembled line; word w is at [32w+:32].

## Operation
- Address split: offset = addr[5:0], set = addr[6+:SET_BITS], tag = addr[31:6+SET_BITS].
- States: IDLE, FILL, DONE.
- IDLE:
  - cache_hit_o = ~req_valid_i | lookup_hit_i.
  - On req_valid_i & ~lookup_hit_i: latch req_addr_i into miss_addr, clear beat_cnt (3 bits), go to FILL.
- FILL:
  - cache_hit_o = 0.
  - Each cycle with rep_ready_i=1: line_buf[64*beat_cnt+:64] ← rep_word_i, then beat_cnt++.
  - Cycles with rep_ready_i=0 capture nothing and do not advance beat_cnt.
  - Capture with beat_cnt=7 → go to DONE.
- DONE (exactly one cycle):
  - cache_hit_o = 1, fill_we_o = 1.
  - fill_set_o and fill_tag_o come from miss_addr; fill_line_o = line_buf.
  - rep_ready_i is ignored here; the responder still shows a stale beat in this cycle.
  - Always return to IDLE.
- stall_o = req_valid_i & ~(state==IDLE & lookup_hit_i). It stays high through DONE; the refetch hits in the following IDLE cycle.
- fill_line_o and fill_tag_o may reflect internal registers at all times; they are only meaningful while fill_we_o=1.
- req_addr_i is never used after miss_addr is latched. Changes to req_addr_i during FILL do not affect the fill.
- Reset (including mid-FILL):
  - state←IDLE, beat_cnt←0, fill_we_o=0, stall_o=0, cache_hit_o=1. cache_hit_o is forced to 1 while reset_i is high.
  - Any partial line is discarded with no write.
  - line_buf and miss_addr are not reset.

## Timing
- Miss seen in IDLE at cycle 0:
  - The responder latches the block address at the cycle-1 edge.
  - Beats 0..7 are captured in cycles 1..8.
  - DONE (fill_we_o=1) in cycle 9.
  - IDLE with a hit and stall_o=0 in cycle 10.
  - Miss penalty = 10 cycles.
- Each responder gap cycle (rep_ready_i=0 within FILL) adds one cycle.
- cache_hit_o=1 in DONE is what returns the responder to its idle state at the end of that cycle, so rep_ready_i=0 from cycle 10.
- A new miss in cycle 10 starts the next fill immediately; there is no dead cycle.
- Hit path: zero added latency. cache_hit_o and stall_o are combinational from lookup_hit_i and req_valid_i in IDLE.
- All state changes happen on the rising edge of clk_i only.

## Structure
- Shared package icache_pkg holds:
  - refill_state_t (IDLE, FILL, DONE).
  - LINE_BYTES=64, BEAT_BITS=64, BEATS_PER_LINE=8, LINE_BITS=512.
- Sub-module refill_line_buf: 8×64-bit beat-indexed capture register with a write-enable and an index input, and a flat 512-bit output.
- The FSM, address latch and output decode live in icache_refill_ctrl.

## Test plan
- Single miss, with memory word i preloaded to value 0x1000+i: request addr 0x0000_0104 miss at cycle 0.
  - fill_we_o pulses in cycle 9 only.
  - fill_set_o=4, fill_tag_o=0.
  - fill_line_o word w = 0x1040+w.
  - stall_o falls in cycle 10.
- Hit, and req_valid_i=0: cache_hit_o=1 and stall_o=0 (for the hit) / stall_o=0 (for req_valid_i=0). No fill_we_o, and rep_ready_i stays 0 for 20 cycles.
- Back-to-back misses to 0x40 then 0x80 (second miss presented in cycle 10):
  - fill_we_o pulses in cycles 9 and 19.
  - fill_set_o = 1 then 2.
  - Line contents match each block.
- Responder stub drops rep_ready_i for 2 cycles after beat 3: only 8 captures occur, the line is correct, and fill_we_o moves to cycle 11.
- reset_i asserted in cycle 5 of a fill:
  - No fill_we_o.
  - cache_hit_o=1 and stall_o=0 during reset.
  - The next miss completes a clean fill with penalty 10.
- req_addr_i changed to 0x2000 during FILL: the fill still targets the latched miss address.
